// File: rtl/seg_pkg.sv
// seg_pkg: shared types and helpers for the segment-display page scheduler.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package seg_pkg;

   localparam int NUM_SRC = 4;
   localparam int PAGE_W  = 32;
   localparam int SRC_W   = $clog2(NUM_SRC);

   typedef logic [SRC_W-1:0]   src_idx_t;
   typedef logic [NUM_SRC-1:0] src_vec_t;
   typedef logic [PAGE_W-1:0]  page_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_HOLD = 2'd2
   } sched_state_t;

   // First requesting source strictly after ptr, wrapping; ptr itself is
   // checked last. Scanning from the far end lets the nearest hit win.
   // Returns ptr when nothing requests (callers gate on |req).
   function automatic src_idx_t rr_pick(input src_idx_t ptr, input src_vec_t req);
      src_idx_t idx;
      rr_pick = ptr;
      for (int i = NUM_SRC; i >= 1; i--) begin
         idx = src_idx_t'((int'(ptr) + i) % NUM_SRC);
         if (req[idx]) begin
            rr_pick = idx;
         end
      end
   endfunction

   function automatic src_vec_t onehot(input src_idx_t idx);
      onehot      = '0;
      onehot[idx] = 1'b1;
   endfunction

endpackage

// File: rtl/seg_ms_tick.sv
// seg_ms_tick: millisecond prescaler producing a one-cycle tick every DIV clocks.
// Latency: first tick DIV cycles after the edge that samples i_clr (or reset).
// Backpressure: none; free-running, i_clr restarts the period.
// Ports: i_clk clock; i_rst sync active-high reset; i_clr restart period;
//        o_tick one-cycle pulse (decode of the counter register).
module seg_ms_tick #(
   parameter int DIV = 50_000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   output logic o_tick
);

   localparam int            CW   = $clog2(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         cnt_q <= '0;
      end else if (cnt_q == LAST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign o_tick = (cnt_q == LAST);

endmodule

// File: rtl/seg_page_sched.sv
// seg_page_sched: round-robin time-multiplexer of four 32-bit hex pages onto seg_disp.
// Latency: request sampled in IDLE -> LOAD on that edge -> grant/page/valid_go registered next edge.
// Backpressure: none; requests are levels, a dropped request aborts the dwell without o_done.
// Ports: i_clk/i_rst clock and sync reset; i_req/i_data/i_blink per-source request, page, blink;
//        o_grant one-hot owner; o_done dwell-complete pulse; o_disp_* drive seg_disp.
module seg_page_sched
   import seg_pkg::*;
#(
   parameter int CLK_FREQ = 50_000_000,
   parameter int HOLD_MS  = 1000,
   parameter int BLINK_MS = 250
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [NUM_SRC-1:0]    i_req,
   input  logic [NUM_SRC*PAGE_W-1:0] i_data,
   input  logic [NUM_SRC-1:0]    i_blink,
   output logic [NUM_SRC-1:0]    o_grant,
   output logic [NUM_SRC-1:0]    o_done,
   output logic                  o_disp_en,
   output logic [PAGE_W-1:0]     o_disp_data,
   output logic                  o_disp_data_valid_go
);

   localparam int                  HOLD_CW    = $clog2(HOLD_MS + 1);
   localparam int                  BLINK_CW   = $clog2(BLINK_MS + 1);
   localparam logic [HOLD_CW-1:0]  HOLD_LAST  = HOLD_CW'(HOLD_MS);
   localparam logic [BLINK_CW-1:0] BLINK_LAST = BLINK_CW'(BLINK_MS);

   sched_state_t         state_q, state_d;
   src_idx_t             g_q, g_d;
   src_idx_t             rr_q, rr_d;
   logic [HOLD_CW-1:0]   hold_cnt_q, hold_cnt_d, hold_inc;
   logic [BLINK_CW-1:0]  blink_cnt_q, blink_cnt_d, blink_inc;
   src_vec_t             grant_q, grant_d;
   src_vec_t             done_q, done_d;
   logic                 en_q, en_d;
   page_t                data_q, data_d;
   logic                 vgo_q, vgo_d;

   page_t                page [NUM_SRC];
   page_t                cur_page;
   logic                 ms_tick;
   logic                 ms_clr;

   for (genvar s = 0; s < NUM_SRC; s++) begin : g_page
      assign page[s] = i_data[s*PAGE_W +: PAGE_W];
   end

   assign cur_page  = page[g_q];
   assign hold_inc  = hold_cnt_q + 1'b1;
   assign blink_inc = blink_cnt_q + 1'b1;

   // Restarting the prescaler in LOAD aligns every dwell to whole ms
   // measured from the moment the page went on screen.
   assign ms_clr = (state_q == ST_LOAD);

   seg_ms_tick #(
      .DIV (CLK_FREQ / 1000)
   ) u_ms_tick (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_clr  (ms_clr),
      .o_tick (ms_tick)
   );

   always_comb begin
      state_d     = state_q;
      g_d         = g_q;
      rr_d        = rr_q;
      hold_cnt_d  = hold_cnt_q;
      blink_cnt_d = blink_cnt_q;
      grant_d     = grant_q;
      done_d      = '0;
      en_d        = en_q;
      data_d      = data_q;
      vgo_d       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            grant_d = '0;
            en_d    = 1'b0;
            if (|i_req) begin
               g_d     = rr_pick(rr_q, i_req);
               state_d = ST_LOAD;
            end
         end

         ST_LOAD: begin
            data_d      = cur_page;
            grant_d     = onehot(g_q);
            vgo_d       = 1'b1;
            en_d        = 1'b1;
            hold_cnt_d  = '0;
            blink_cnt_d = '0;
            rr_d        = g_q;
            state_d     = ST_HOLD;
         end

         ST_HOLD: begin
            if (!i_req[g_q]) begin
               // Abort outranks expiry on the same edge: no o_done.
               state_d = ST_IDLE;
               grant_d = '0;
               en_d    = 1'b0;
            end else begin
               // Live page edits are picked up once per ms, only when changed,
               // so seg_disp sees at most one refresh per ms.
               if (ms_tick && (cur_page != data_q)) begin
                  data_d = cur_page;
                  vgo_d  = 1'b1;
               end

               if (i_blink[g_q]) begin
                  if (ms_tick) begin
                     if (blink_inc == BLINK_LAST) begin
                        en_d        = ~en_q;
                        blink_cnt_d = '0;
                     end else begin
                        blink_cnt_d = blink_inc;
                     end
                  end
               end else begin
                  // Restart the blink phase so re-enabling begins a full "on" half-period.
                  en_d        = 1'b1;
                  blink_cnt_d = '0;
               end

               if (ms_tick) begin
                  hold_cnt_d = hold_inc;
                  if (hold_inc == HOLD_LAST) begin
                     done_d = onehot(g_q);
                     // rr_q == g_q here, so any other requester wins ahead of g;
                     // g still requests (no abort), so a winner always exists.
                     g_d     = rr_pick(rr_q, i_req);
                     state_d = ST_LOAD;
                  end
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         g_q         <= '0;
         rr_q        <= src_idx_t'(NUM_SRC - 1);
         hold_cnt_q  <= '0;
         blink_cnt_q <= '0;
         grant_q     <= '0;
         done_q      <= '0;
         en_q        <= 1'b0;
         data_q      <= '0;
         vgo_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         g_q         <= g_d;
         rr_q        <= rr_d;
         hold_cnt_q  <= hold_cnt_d;
         blink_cnt_q <= blink_cnt_d;
         grant_q     <= grant_d;
         done_q      <= done_d;
         en_q        <= en_d;
         data_q      <= data_d;
         vgo_q       <= vgo_d;
      end
   end

   assign o_grant              = grant_q;
   assign o_done               = done_q;
   assign o_disp_en            = en_q;
   assign o_disp_data          = data_q;
   assign o_disp_data_valid_go = vgo_q;

endmodule

// File: tb/tb_seg_page_sched.sv
// tb_seg_page_sched: directed scenarios plus randomized traffic against a
// time-based reference model of the page scheduler (10 clocks per ms).
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_seg_page_sched;

   localparam int CLK_FREQ = 10000;
   localparam int HOLD_MS  = 3;
   localparam int BLINK_MS = 1;
   localparam int MSC      = CLK_FREQ / 1000;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req;
   logic [3:0]   blink;
   logic [31:0]  page [4];
   logic [127:0] data;
   logic [3:0]   grant, done;
   logic         disp_en, vgo;
   logic [31:0]  disp_data;

   int vectors     = 0;
   int miscompares = 0;
   bit chk_en      = 1'b0;

   assign data = {page[3], page[2], page[1], page[0]};

   always #5 clk = ~clk;

   seg_page_sched #(
      .CLK_FREQ (CLK_FREQ),
      .HOLD_MS  (HOLD_MS),
      .BLINK_MS (BLINK_MS)
   ) dut (
      .i_clk                (clk),
      .i_rst                (rst),
      .i_req                (req),
      .i_data               (data),
      .i_blink              (blink),
      .o_grant              (grant),
      .o_done               (done),
      .o_disp_en            (disp_en),
      .o_disp_data          (disp_data),
      .o_disp_data_valid_go (vgo)
   );

   // ---------------- reference model ----------------
   // Tracks who is served and how many clocks have elapsed since the page
   // went on screen; ms boundaries and expiry follow from that age directly.
   logic [3:0]  e_grant = '0, e_done = '0;
   logic        e_en = 1'b0, e_vgo = 1'b0;
   logic [31:0] e_data = '0;
   int m_mode  = 0;   // 0 nobody, 1 winner chosen awaiting load, 2 on screen
   int m_src   = 0;
   int m_last  = 3;   // most recently loaded source
   int m_age   = 0;
   int m_bt    = 0;   // ms elapsed in the current blink half-period

   function automatic int next_after(input int after, input logic [3:0] r);
      for (int i = 1; i <= 4; i++) begin
         if (r[(after + i) % 4]) return (after + i) % 4;
      end
      return -1;
   endfunction

   task automatic model_step();
      bit on_ms;
      if (rst) begin
         e_grant = '0; e_done = '0; e_en = 1'b0; e_vgo = 1'b0; e_data = '0;
         m_mode = 0; m_src = 0; m_last = 3; m_age = 0; m_bt = 0;
         return;
      end
      e_done = '0;
      e_vgo  = 1'b0;
      if (m_mode == 0) begin
         if (req != 4'b0) begin
            m_src  = next_after(m_last, req);
            m_mode = 1;
         end
      end else if (m_mode == 1) begin
         e_data  = page[m_src];
         e_grant = 4'(1 << m_src);
         e_vgo   = 1'b1;
         e_en    = 1'b1;
         m_last  = m_src;
         m_age   = 0;
         m_bt    = 0;
         m_mode  = 2;
      end else begin
         m_age++;
         on_ms = (m_age % MSC) == 0;
         if (!req[m_src]) begin
            m_mode  = 0;
            e_grant = '0;
            e_en    = 1'b0;
         end else begin
            if (on_ms && page[m_src] != e_data) begin
               e_data = page[m_src];
               e_vgo  = 1'b1;
            end
            if (blink[m_src]) begin
               if (on_ms) begin
                  m_bt++;
                  if (m_bt == BLINK_MS) begin
                     e_en = ~e_en;
                     m_bt = 0;
                  end
               end
            end else begin
               e_en = 1'b1;
               m_bt = 0;
            end
            if (m_age == HOLD_MS * MSC) begin
               e_done = 4'(1 << m_src);
               m_src  = next_after(m_last, req);
               m_mode = 1;
            end
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         vectors++;
         if (grant !== e_grant || done !== e_done || disp_en !== e_en ||
             disp_data !== e_data || vgo !== e_vgo) begin
            miscompares++;
            $display("FAIL model_cycle t=%0t dut/exp grant %b/%b done %b/%b en %b/%b data %h/%h vgo %b/%b",
                     $time, grant, e_grant, done, e_done, disp_en, e_en, disp_data, e_data, vgo, e_vgo);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   logic [3:0] rr_exp [4];
   logic [3:0] got [$];

   initial begin
      rst = 1'b1; req = '0; blink = '0;
      for (int i = 0; i < 4; i++) page[i] = '0;
      step(2);
      chk_en = 1'b1;

      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_en", 32'(disp_en), 32'h0);
      chk("rst_data", disp_data, 32'h0);
      chk("rst_vgo", 32'(vgo), 32'h0);

      // Single requester: first sampled on the next rising edge P,
      // on screen after P+1, o_done after P+31, reload after P+32.
      page[0] = 32'habcdef12; page[1] = 32'h11111111;
      page[2] = 32'h22222222; page[3] = 32'h33333333;
      rst = 1'b0; req = 4'b0001;
      step(1); chk("t1_load_grant", 32'(grant), 32'h0);
      step(1);
      chk("t1_grant", 32'(grant), 32'h1);
      chk("t1_data", disp_data, 32'habcdef12);
      chk("t1_vgo", 32'(vgo), 32'h1);
      chk("t1_en", 32'(disp_en), 32'h1);
      step(1); chk("t1_vgo_pulse", 32'(vgo), 32'h0);
      step(28); chk("t1_done_early", 32'(done), 32'h0);
      step(1); chk("t1_done", 32'(done), 32'h1);
      step(1); chk("t1_reload_vgo", 32'(vgo), 32'h1);

      // Drop source 0 in mid-dwell with source 1 waiting.
      step(14); req = 4'b0010;
      step(1);
      chk("t5_abort_grant", 32'(grant), 32'h0);
      chk("t5_abort_done", 32'(done), 32'h0);
      step(2);
      chk("t5_next_grant", 32'(grant), 32'h2);
      chk("t5_next_data", disp_data, 32'h11111111);

      // Reset during a dwell, then everyone requests.
      step(12); rst = 1'b1;
      step(1);
      chk("t6_rst_grant", 32'(grant), 32'h0);
      chk("t6_rst_en", 32'(disp_en), 32'h0);
      chk("t6_rst_data", disp_data, 32'h0);
      rst = 1'b0; req = 4'b1111;
      step(2); chk("t6_first_grant", 32'(grant), 32'h1);

      // Round-robin order with sources 0,1,3.
      rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b1000; rr_exp[3] = 4'b0001;
      rst = 1'b1; step(1);
      rst = 1'b0; req = 4'b1011;
      got.delete();
      for (int c = 0; c < 140 && got.size() < 4; c++) begin
         step(1);
         if (vgo) got.push_back(grant);
      end
      if (got.size() < 4) begin
         vectors++; miscompares++;
         $display("FAIL rr_order: only %0d loads seen, required 4", got.size());
      end else begin
         for (int i = 0; i < 4; i++) chk("rr_order", 32'(got[i]), 32'(rr_exp[i]));
      end

      // Blink on source 2: on for 10 clocks, off for 10; clearing blink forces on.
      rst = 1'b1; step(1);
      rst = 1'b0; req = 4'b0100; blink = 4'b0100;
      step(2);  chk("t3_en_start", 32'(disp_en), 32'h1);
      step(9);  chk("t3_en_last_on", 32'(disp_en), 32'h1);
      step(1);  chk("t3_en_off", 32'(disp_en), 32'h0);
      step(3);  blink = 4'b0000;
      step(1);  chk("t3_en_forced", 32'(disp_en), 32'h1);
      blink = 4'b0100;
      step(40);

      // Page edit while on screen.
      blink = '0; page[0] = 32'h12345678; req = 4'b0001;
      step(17); page[0] = 32'h87654321;
      step(60);

      // Abort on the very edge the dwell would expire.
      rst = 1'b1; step(1);
      rst = 1'b0; req = 4'b0011;
      step(31); req = 4'b0010;
      step(1);
      chk("t5_coincident_done", 32'(done), 32'h0);
      chk("t5_coincident_grant", 32'(grant), 32'h0);
      step(5);

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 24) == 0) req = 4'($urandom);
         if ($urandom_range(0, 7) == 0) page[$urandom_range(0, 3)] = $urandom;
         if ($urandom_range(0, 39) == 0) blink = 4'($urandom);
         rst = ($urandom_range(0, 599) == 0);
         step(1);
      end
      rst = 1'b0;
      step(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
